// File: rtl/button_conditioner.sv
// Conditions the five raw Nexys A7 push-buttons into debounced levels, direction press strobes and
// centre short/long strobes. Define BUTTON_AUTOREPEAT_EN to enable auto-repeat on the direction buttons.
module button_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES      = 360000,
  parameter int unsigned LONG_PRESS_CYCLES    = 18000000,
  parameter int unsigned REPEAT_DELAY_CYCLES  = 14400000,
  parameter int unsigned REPEAT_PERIOD_CYCLES = 3600000
) (
  input  logic       pixel_clk,
  input  logic       rst_n,
  input  logic [4:0] btn_raw,
  output logic [4:0] btn_level,
  output logic       pulse_u,
  output logic       pulse_d,
  output logic       pulse_r,
  output logic       pulse_l,
  output logic       c_short,
  output logic       c_long
);

  localparam int unsigned NUM_BTN = 5;
  localparam int unsigned NUM_DIR = 4;
  localparam int unsigned BTN_C   = 4;
  localparam int unsigned DB_W    = $clog2(DEBOUNCE_CYCLES);
  localparam int unsigned HOLD_W  = $clog2(LONG_PRESS_CYCLES);

  if (DEBOUNCE_CYCLES < 2 || LONG_PRESS_CYCLES <= DEBOUNCE_CYCLES ||
      REPEAT_DELAY_CYCLES < 1 || REPEAT_PERIOD_CYCLES < 1) begin : g_bad_params
    $error("button_conditioner: illegal cycle-count parameters");
  end

  typedef enum logic [1:0] {
    C_IDLE,
    C_HELD,
    C_LONG_DONE
  } c_state_t;

  logic [NUM_BTN-1:0] sync1;
  logic [NUM_BTN-1:0] sync2;
  logic [NUM_BTN-1:0] level_d;
  logic [DB_W-1:0]    db_cnt [NUM_BTN];
  logic [NUM_BTN-1:0] rise;
  logic               c_fall;
  logic [NUM_DIR-1:0] dir_pulse;
  c_state_t           c_state;
  logic [HOLD_W-1:0]  hold_cnt;

  // Two-flop synchroniser plus one-cycle delayed level for edge detection
  always_ff @(posedge pixel_clk) begin
    if (!rst_n) begin
      sync1   <= '0;
      sync2   <= '0;
      level_d <= '0;
    end else begin
      sync1   <= btn_raw;
      sync2   <= sync1;
      level_d <= btn_level;
    end
  end

  // Per-button debouncer: level flips only after DEBOUNCE_CYCLES of continuous mismatch
  always_ff @(posedge pixel_clk) begin
    if (!rst_n) begin
      btn_level <= '0;
      for (int i = 0; i < NUM_BTN; i++) db_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_BTN; i++) begin
        if (sync2[i] == btn_level[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_W'(DEBOUNCE_CYCLES - 1)) begin
          btn_level[i] <= ~btn_level[i];
          db_cnt[i]    <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + DB_W'(1);
        end
      end
    end
  end

  assign rise   = btn_level & ~level_d;
  assign c_fall = level_d[BTN_C] & ~btn_level[BTN_C];

`ifdef BUTTON_AUTOREPEAT_EN
  localparam int unsigned REP_MAX = (REPEAT_DELAY_CYCLES > REPEAT_PERIOD_CYCLES) ?
                                    REPEAT_DELAY_CYCLES : REPEAT_PERIOD_CYCLES;
  localparam int unsigned REP_W   = $clog2(REP_MAX + 1);

  logic [REP_W-1:0]   rep_cnt [NUM_DIR];
  logic [NUM_DIR-1:0] rep_phase;

  // Press strobe, then repeats after the initial delay and every period while the level stays high
  always_ff @(posedge pixel_clk) begin
    if (!rst_n) begin
      dir_pulse <= '0;
      rep_phase <= '0;
      for (int i = 0; i < NUM_DIR; i++) rep_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_DIR; i++) begin
        dir_pulse[i] <= 1'b0;
        if (rise[i]) begin
          dir_pulse[i] <= 1'b1;
          rep_cnt[i]   <= '0;
          rep_phase[i] <= 1'b0;
        end else if (!btn_level[i]) begin
          rep_cnt[i]   <= '0;
          rep_phase[i] <= 1'b0;
        end else if (rep_cnt[i] == (rep_phase[i] ? REP_W'(REPEAT_PERIOD_CYCLES - 1)
                                                 : REP_W'(REPEAT_DELAY_CYCLES - 1))) begin
          dir_pulse[i] <= 1'b1;
          rep_cnt[i]   <= '0;
          rep_phase[i] <= 1'b1;
        end else begin
          rep_cnt[i] <= rep_cnt[i] + REP_W'(1);
        end
      end
    end
  end
`else
  // One strobe per debounced press
  always_ff @(posedge pixel_clk) begin
    if (!rst_n) dir_pulse <= '0;
    else        dir_pulse <= rise[NUM_DIR-1:0];
  end
`endif

  assign pulse_u = dir_pulse[3];
  assign pulse_d = dir_pulse[2];
  assign pulse_r = dir_pulse[1];
  assign pulse_l = dir_pulse[0];

  // Centre button: release before the hold limit is short, reaching the limit is long
  always_ff @(posedge pixel_clk) begin
    if (!rst_n) begin
      c_state  <= C_IDLE;
      hold_cnt <= '0;
      c_short  <= 1'b0;
      c_long   <= 1'b0;
    end else begin
      c_short <= 1'b0;
      c_long  <= 1'b0;
      case (c_state)
        C_IDLE: begin
          if (rise[BTN_C]) begin
            hold_cnt <= '0;
            c_state  <= C_HELD;
          end
        end
        C_HELD: begin
          if (c_fall) begin
            c_short <= 1'b1;
            c_state <= C_IDLE;
          end else if (hold_cnt == HOLD_W'(LONG_PRESS_CYCLES - 1)) begin
            c_long  <= 1'b1;
            c_state <= C_LONG_DONE;
          end else begin
            hold_cnt <= hold_cnt + HOLD_W'(1);
          end
        end
        C_LONG_DONE: begin
          if (c_fall) c_state <= C_IDLE;
        end
        default: c_state <= C_IDLE;
      endcase
    end
  end

endmodule

// File: doc/button_conditioner.md
# button_conditioner

Front-end conditioner that turns the five raw push-button inputs of the Nexys A7 into the clean control strobes consumed by the game logic: single-cycle direction pulses for `button_u/d/l/r` and the `button_c_short` / `button_c_long` pair expected by `game_fsm`. It sits between the board pins and the `game` top-level. It performs:

- synchronisation into `pixel_clk`;
- per-button debouncing;
- edge-to-pulse conversion;
- short/long classification of the centre button.

## Interface

Parameters:

- `DEBOUNCE_CYCLES`, default 360000 — consecutive stable cycles required to accept a level change (10 ms at 36 MHz); minimum 2.
- `LONG_PRESS_CYCLES`, default 18000000 — centre-button hold length classified as long (500 ms); must exceed `DEBOUNCE_CYCLES`.
- `REPEAT_DELAY_CYCLES`, default 14400000 — hold time before the first auto-repeat pulse (400 ms).
- `REPEAT_PERIOD_CYCLES`, default 3600000 — interval between subsequent auto-repeat pulses (100 ms).

Ports:

- `pixel_clk` input 1 — pixel clock, 36 MHz.
- `rst_n` input 1 — reset; synchronous, active-low; clock `pixel_clk`.
- `btn_raw` input 5 — asynchronous raw buttons, active-high; bit order {c,u,d,r,l} = [4:0].
- `btn_level` output 5 — debounced levels, same bit order.
- `pulse_u`, `pulse_d`, `pulse_r`, `pulse_l` output 1 each — one-cycle press strobes.
- `c_short` output 1 — one-cycle strobe on release of a short centre press.
- `c_long` output 1 — one-cycle strobe when a centre hold reaches `LONG_PRESS_CYCLES`.

## Operation

Synchroniser:
- Two-flop synchroniser per bit.
- Reset value 0.

Debouncer (one independent instance per bit):
- Counter width is `$clog2(DEBOUNCE_CYCLES)`.
- The counter is cleared whenever the synchronised input equals `btn_level`.
- The counter increments on every cycle of mismatch.
- When the counter reaches `DEBOUNCE_CYCLES-1` while the mismatch persists, `btn_level` toggles and the counter clears.
- A glitch shorter than `DEBOUNCE_CYCLES` never changes `btn_level`.

Direction pulses (u/d/r/l):
- `pulse_x` is registered high for exactly one cycle on the cycle after a 0→1 transition of the debounced level.
- Release produces no pulse.

Centre FSM, with a saturating hold counter sized by `$clog2(LONG_PRESS_CYCLES)`:
- IDLE: on a debounced rising edge, clear the counter and go to HELD.
- HELD: the counter increments each cycle.
  - When the counter reaches `LONG_PRESS_CYCLES-1`: assert `c_long` for one cycle, then go to LONG_DONE.
  - On a debounced falling edge before that: assert `c_short` for one cycle, then go to IDLE.
  - If both conditions occur in the same cycle, the release wins: `c_short` only.
- LONG_DONE: wait for the debounced falling edge, then go to IDLE. No `c_short` is issued.
- `c_short` and `c_long` are never both asserted for one press.

Buttons are fully independent:
- Several pulses may assert in the same cycle.
- No priority is applied.

Reset:
- Outputs at reset: all outputs 0, `btn_level` = 0, FSM in IDLE, all counters 0.
- Reset asserted mid-press: all state is discarded and no pending strobe is emitted.
- A button still held when reset releases is seen as a new press after the debounce time and produces a normal pulse.

## Timing

- All outputs are registered.
- Latency from a raw edge to a `btn_level` change: 2 synchroniser cycles + `DEBOUNCE_CYCLES` cycles.
- Pulses appear one cycle after the `btn_level` change.
- Raw press to `pulse_x`: `DEBOUNCE_CYCLES`+3 cycles.
- `c_long` is asserted `LONG_PRESS_CYCLES` cycles after the cycle in which HELD is entered.
- `c_short` is asserted one cycle after the debounced falling edge.
- Pulses are one `pixel_clk` cycle wide. Downstream logic samples them every cycle; no handshake is used.

## Configuration

Macro `BUTTON_AUTOREPEAT_EN` controls auto-repeat on the direction buttons.

With `BUTTON_AUTOREPEAT_EN` defined:
- Each direction button has a repeat counter, cleared on the press pulse.
- While `btn_level` stays high, an extra one-cycle `pulse_x` is emitted `REPEAT_DELAY_CYCLES` after the press pulse.
- After that, a further pulse is emitted every `REPEAT_PERIOD_CYCLES`.
- Release stops repetition immediately, including when release coincides with a repeat deadline: no pulse in that case.

Without `BUTTON_AUTOREPEAT_EN`:
- Exactly one pulse per press.
- The repeat counters are not synthesised.
- The centre button never auto-repeats in either build.

## Test plan

All scenarios use `DEBOUNCE_CYCLES`=4, `LONG_PRESS_CYCLES`=20, `REPEAT_DELAY_CYCLES`=10, `REPEAT_PERIOD_CYCLES`=5.

- Reset check: `rst_n`=0 for 3 cycles with `btn_raw`=5'h1F → all outputs 0 throughout reset. After release, all four direction pulses fire together 7 cycles later, then `c_long` fires after the hold limit.
- Bounce rejection: `btn_raw[3]` toggles high for 3 cycles, low for 1, high for 3 → no `pulse_u`. Hold high steady → `pulse_u` high exactly 1 cycle, 7 cycles after the last rising edge.
- Short press: `btn_raw[4]` high for 10 cycles → `c_short` one cycle after the debounced falling edge, no `c_long`.
- Long press: `btn_raw[4]` high for 40 cycles → `c_long` 20 cycles after HELD entry. No `c_short` on release. A second press behaves normally.
- Auto-repeat (macro defined): hold `btn_raw[0]` for 30 debounced cycles → `pulse_l` at press+0, +10, +15, +20, +25, +30 relative to the first pulse, with none after release. Macro undefined → a single pulse.
- Reset mid-hold: assert `rst_n`=0 while the centre FSM is in HELD at count 15 → neither `c_long` nor `c_short` is ever emitted for that press.
